// File: rtl/core_seq_ctrl_pkg.sv
// Shared state encoding and instruction-word layout for the core instruction sequencer.
package core_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HLOAD = 3'd1,
    WREAD = 3'd2,
    KLOAD = 3'd3,
    XREAD = 3'd4,
    EXEC  = 3'd5,
    DRAIN = 3'd6,
    DONE  = 3'd7
  } seqState_t;

  localparam int INST_W      = 34;
  localparam int ACC_BIT     = 33;
  localparam int PCEN_BIT    = 32;
  localparam int PWEN_BIT    = 31;
  localparam int PADDR_LSB   = 20;
  localparam int XCEN_BIT    = 19;
  localparam int XWEN_BIT    = 18;
  localparam int XADDR_LSB   = 7;
  localparam int OFIFO_RD_BIT = 6;
  localparam int IFIFO_WR_BIT = 5;
  localparam int IFIFO_RD_BIT = 4;
  localparam int L0_RD_BIT   = 3;
  localparam int L0_WR_BIT   = 2;
  localparam int EXEC_BIT    = 1;
  localparam int LOAD_BIT    = 0;

  // Both SRAMs deselected and write-disabled, everything else quiet.
  localparam logic [INST_W-1:0] IDLE_INST = INST_W'((64'd1 << PCEN_BIT) | (64'd1 << PWEN_BIT) |
                                                    (64'd1 << XCEN_BIT) | (64'd1 << XWEN_BIT));

  // inst[7] doubles as the mode bit, so the idle word carries it too.
  function automatic logic [INST_W-1:0] idleWord(input logic m);
    idleWord = IDLE_INST;
    idleWord[XADDR_LSB] = m;
  endfunction

endpackage

// File: rtl/core_seq_ctrl_addr_gen.sv
// Base+index address counter with a one-cycle delayed read strobe covering the SRAM read latency.
module seq_addr_gen #(
  parameter int aw = 11,
  parameter int iw = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic [iw-1:0] clrIdx,
  input  logic          step,
  input  logic          rd,
  input  logic [aw-1:0] base,
  output logic [aw-1:0] addr,
  output logic [iw-1:0] idx,
  output logic          rdDly
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx   <= '0;
      rdDly <= 1'b0;
    end else begin
      rdDly <= step & rd;
      if (clr)       idx <= clrIdx;
      else if (step) idx <= idx + 1'b1;
    end
  end

  // The index is wider than the address so pass-length compares never alias; the address wraps silently.
  assign addr = base + idx[aw-1:0];

endmodule

// File: rtl/core_seq_ctrl.sv
// Instruction sequencer: runs one WS/OS tile pass (host load, kernel load, execute, drain) per start pulse.
//
//   state | meaning
//   IDLE  | waiting for start, idle word on inst
//   HLOAD | accepting host beats into xMem (weights then activations)
//   WREAD | WS only: read weights from xMem into L0
//   KLOAD | WS only: push weights into PE array, then let them propagate
//   XREAD | read activations from xMem into L0
//   EXEC  | stream activations through the array (OS: psum feedback reads)
//   DRAIN | move OFIFO outputs into psumMem, stalling on ofifo_valid
//   DONE  | one-cycle completion pulse
module core_seq_ctrl
  import core_seq_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int len_bw  = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [len_bw-1:0]  x_len,
  input  logic [addr_bw-1:0] x_base,
  input  logic [addr_bw-1:0] p_base,
  input  logic               host_valid,
  output logic               host_ready,
  input  logic               ofifo_valid,
  output logic [33:0]        inst,
  output logic               busy,
  output logic               done
);

  localparam int IW = len_bw + 1;
  localparam logic [IW-1:0]     ROW_I     = IW'(row);
  localparam logic [len_bw-1:0] ROW_L     = len_bw'(row);
  localparam logic [len_bw-1:0] COL_M1    = len_bw'(col - 1);
  localparam logic [len_bw-1:0] KLOAD_LEN = len_bw'(2 * row + col - 1);
  localparam logic [len_bw-1:0] KLOAD_ACT = len_bw'(row + col);

  seqState_t          state;
  logic               modeQ;
  logic [len_bw-1:0]  xLenQ, timer;
  logic [addr_bw-2:0] xBaseQ;
  logic [addr_bw-1:0] pBaseQ;
  logic [INST_W-1:0]  instNext;
  logic [IW-1:0]      lastBeat;

  logic               xClr, xStep, xRd, xRdDly;
  logic [IW-1:0]      xIdx, xClrIdx;
  logic [addr_bw-2:0] xAddr;
  logic               pClr, pStep, pRdDly;
  logic [IW-1:0]      pIdx;
  logic [addr_bw-1:0] pAddr;
  logic               unusedSig;

  assign lastBeat  = ROW_I + {1'b0, xLenQ} - 1'b1;
  assign unusedSig = ^{x_base[0], pIdx, pRdDly};

  seq_addr_gen #(.aw(addr_bw - 1), .iw(IW)) xGen (
    .clk(clk), .reset(reset), .clr(xClr), .clrIdx(xClrIdx), .step(xStep), .rd(xRd),
    .base(xBaseQ), .addr(xAddr), .idx(xIdx), .rdDly(xRdDly)
  );

  seq_addr_gen #(.aw(addr_bw), .iw(IW)) pGen (
    .clk(clk), .reset(reset), .clr(pClr), .clrIdx('0), .step(pStep), .rd(1'b0),
    .base(pBaseQ), .addr(pAddr), .idx(pIdx), .rdDly(pRdDly)
  );

  always_comb begin
    xStep    = 1'b0;
    xRd      = 1'b0;
    xClr     = 1'b0;
    xClrIdx  = '0;
    pStep    = 1'b0;
    pClr     = 1'b0;
    instNext = idleWord(modeQ);
    case (state)
      IDLE: begin
        xClr = 1'b1;
        pClr = 1'b1;
        if (start) instNext = idleWord(mode);
      end
      HLOAD: begin
        xStep = host_valid & host_ready;
        if (xStep) begin
          instNext[XCEN_BIT] = 1'b0;
          instNext[XWEN_BIT] = 1'b0;
          instNext[XADDR_LSB +: addr_bw] = {xAddr, modeQ};
          if (xIdx == lastBeat) begin
            xClr    = 1'b1;
            xClrIdx = modeQ ? ROW_I : '0;
          end
        end
      end
      WREAD, XREAD: begin
        xRd   = 1'b1;
        xStep = (timer != '0);
        instNext[L0_WR_BIT] = xRdDly;
        if (xStep) begin
          instNext[XCEN_BIT] = 1'b0;
          instNext[XADDR_LSB +: addr_bw] = {xAddr, modeQ};
        end else if (state == WREAD) begin
          // Activations live right after the row weight vectors.
          xClr    = 1'b1;
          xClrIdx = ROW_I;
        end
      end
      KLOAD: begin
        if (timer >= KLOAD_ACT) begin
          instNext[L0_RD_BIT] = 1'b1;
          instNext[LOAD_BIT]  = 1'b1;
        end
      end
      EXEC: begin
        instNext[L0_RD_BIT] = 1'b1;
        instNext[EXEC_BIT]  = 1'b1;
        pStep = modeQ;
        pClr  = (timer == '0);
        if (modeQ) begin
          instNext[PCEN_BIT] = 1'b0;
          instNext[PADDR_LSB +: addr_bw] = pAddr;
        end
      end
      DRAIN: begin
        pStep = ofifo_valid;
        if (ofifo_valid) begin
          instNext[OFIFO_RD_BIT] = 1'b1;
          instNext[PCEN_BIT]     = 1'b0;
          instNext[PWEN_BIT]     = 1'b0;
          instNext[ACC_BIT]      = modeQ;
          instNext[PADDR_LSB +: addr_bw] = pAddr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      inst       <= IDLE_INST;
      host_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      modeQ      <= 1'b0;
      xLenQ      <= '0;
      xBaseQ     <= '0;
      pBaseQ     <= '0;
      timer      <= '0;
    end else begin
      inst <= instNext;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          modeQ  <= mode;
          xLenQ  <= x_len;
          xBaseQ <= x_base[addr_bw-1:1];
          pBaseQ <= p_base;
          busy   <= 1'b1;
          if (x_len == '0) state <= DONE;
          else begin
            state      <= HLOAD;
            host_ready <= 1'b1;
          end
        end
        HLOAD: if (xStep && xIdx == lastBeat) begin
          host_ready <= 1'b0;
          state      <= modeQ ? XREAD : WREAD;
          timer      <= modeQ ? xLenQ : ROW_L;
        end
        WREAD: if (timer == '0) begin
          state <= KLOAD;
          timer <= KLOAD_LEN;
        end else timer <= timer - 1'b1;
        KLOAD: if (timer == '0) begin
          state <= XREAD;
          timer <= xLenQ;
        end else timer <= timer - 1'b1;
        XREAD: if (timer == '0) begin
          state <= EXEC;
          timer <= xLenQ - 1'b1;
        end else timer <= timer - 1'b1;
        EXEC: if (timer == '0) begin
          state <= DRAIN;
          timer <= modeQ ? COL_M1 : xLenQ - 1'b1;
        end else timer <= timer - 1'b1;
        DRAIN: if (ofifo_valid) begin
          if (timer == '0) state <= DONE;
          else timer <= timer - 1'b1;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: directed and randomized tile passes checked against an event-level pass model.
module tb_core_seq_ctrl;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset, start, mode, host_valid, host_ready, ofifo_valid, busy, done;
  logic [10:0] x_len, x_base, p_base;
  logic [33:0] inst;

  int errCnt = 0;
  int chkCnt = 0;

  core_seq_ctrl #(.row(ROW), .col(COL), .addr_bw(11), .len_bw(11)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .x_len(x_len), .x_base(x_base),
    .p_base(p_base), .host_valid(host_valid), .host_ready(host_ready), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    chkCnt++;
    if (obs !== expv) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---- monitor: turns the per-cycle instruction stream into pass-level events
  bit   monOn = 0;
  logic curMode = 1'b0;
  bit   prevBeat = 0;
  int   xWrQ[$], xRdQ[$], pRdQ[$], pWrQ[$];
  int   l0WrCnt, l0RdCnt, loadCnt, execCnt, accBad, lsbBad, hsBad, gapBad;
  int   doneCnt, busyCnt, hrCnt, rdSeen, spanFirst, spanLast, cyc;

  always @(negedge clk) if (monOn) begin
    cyc++;
    if (busy) busyCnt++;
    if (host_ready) hrCnt++;
    if (done) doneCnt++;
    if (!inst[19] && !inst[18]) xWrQ.push_back(int'(inst[17:7]));
    if (!inst[19] && inst[18]) xRdQ.push_back(int'(inst[17:7]));
    if (!inst[19] && inst[7] !== curMode) lsbBad++;
    if ((!inst[19] && !inst[18]) != prevBeat) hsBad++;
    prevBeat = host_valid & host_ready;
    l0WrCnt += int'(inst[2]);
    l0RdCnt += int'(inst[3]);
    loadCnt += int'(inst[0]);
    execCnt += int'(inst[1]);
    if (!inst[32] && inst[31]) pRdQ.push_back(int'(inst[30:20]));
    if (!inst[32] && !inst[31]) begin
      pWrQ.push_back(int'(inst[30:20]));
      if (inst[33] !== curMode) accBad++;
    end
    if (inst[6]) begin
      rdSeen++;
      if (spanFirst < 0) spanFirst = cyc;
      spanLast = cyc;
      if (inst[32] || inst[31]) gapBad++;
    end else if (spanFirst >= 0 && !inst[32]) gapBad++;
  end

  // ---- input drivers
  int hvMode = 2;
  bit stallArm = 0;
  int stallLeft = 0;

  initial begin
    host_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (hvMode)
        0: host_valid = 1'b1;
        1: host_valid = ~host_valid;
        default: host_valid = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    ofifo_valid = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stallArm && rdSeen >= 2 && stallLeft > 0) begin
        ofifo_valid = 1'b0;
        stallLeft--;
      end else ofifo_valid = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- reference model helpers
  function automatic int xAddrOf(input logic [10:0] xb, input int k, input logic m);
    return ((((int'(xb) >> 1) + k) % 1024) * 2) + int'(m);
  endfunction

  task automatic clearMon(input logic m);
    xWrQ.delete(); xRdQ.delete(); pRdQ.delete(); pWrQ.delete();
    l0WrCnt = 0; l0RdCnt = 0; loadCnt = 0; execCnt = 0; accBad = 0; lsbBad = 0;
    hsBad = 0; gapBad = 0; doneCnt = 0; busyCnt = 0; hrCnt = 0; rdSeen = 0;
    spanFirst = -1; spanLast = -1; cyc = 0; prevBeat = 0; curMode = m;
  endtask

  task automatic runPass(input logic m, input int xl, input logic [10:0] xb, input logic [10:0] pb,
                         input int hv, input bit stallReq, input bit restart);
    int   nW, guard, expBusy, stallCyc;
    int   expRd[$];
    bit   stallOn;
    nW       = m ? COL : xl;
    stallOn  = stallReq && (nW >= 4);
    stallCyc = stallOn ? 5 : 0;
    clearMon(m);
    hvMode    = hv;
    stallArm  = stallOn;
    stallLeft = 5;
    monOn     = 1;
    @(posedge clk); #1;
    start = 1'b1; mode = m; x_len = 11'(xl); x_base = xb; p_base = pb;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m; x_len = 11'($urandom); x_base = 11'($urandom); p_base = 11'($urandom);
    if (restart) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    guard = 0;
    while (doneCnt == 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("passTimeout", 64'(guard < 3000), 64'd1);
    repeat (3) @(negedge clk);
    monOn    = 0;
    stallArm = 0;

    chk("xWrCount", 64'(xWrQ.size()), 64'(ROW + xl));
    for (int k = 0; k < ROW + xl; k++)
      if (k < xWrQ.size()) chk("xWrAddr", 64'(xWrQ[k]), 64'(xAddrOf(xb, k, m)));
    if (!m) for (int k = 0; k < ROW; k++) expRd.push_back(xAddrOf(xb, k, m));
    for (int k = ROW; k < ROW + xl; k++) expRd.push_back(xAddrOf(xb, k, m));
    chk("xRdCount", 64'(xRdQ.size()), 64'(expRd.size()));
    for (int k = 0; k < expRd.size(); k++)
      if (k < xRdQ.size()) chk("xRdAddr", 64'(xRdQ[k]), 64'(expRd[k]));
    chk("l0WrCount", 64'(l0WrCnt), 64'(expRd.size()));
    chk("loadCount", 64'(loadCnt), 64'(m ? 0 : ROW));
    chk("execCount", 64'(execCnt), 64'(xl));
    chk("l0RdCount", 64'(l0RdCnt), 64'((m ? 0 : ROW) + xl));
    chk("pRdCount", 64'(pRdQ.size()), 64'(m ? xl : 0));
    for (int j = 0; j < pRdQ.size(); j++) chk("pRdAddr", 64'(pRdQ[j]), 64'((int'(pb) + j) % 2048));
    chk("pWrCount", 64'(pWrQ.size()), 64'(nW));
    for (int j = 0; j < pWrQ.size(); j++) chk("pWrAddr", 64'(pWrQ[j]), 64'((int'(pb) + j) % 2048));
    chk("accBits", 64'(accBad), 64'd0);
    chk("xAddrLsb", 64'(lsbBad), 64'd0);
    chk("handshake", 64'(hsBad), 64'd0);
    chk("drainGaps", 64'(gapBad), 64'd0);
    chk("drainSpan", 64'(spanLast - spanFirst + 1), 64'(nW + stallCyc));
    chk("doneCount", 64'(doneCnt), 64'd1);
    if (hv == 0) chk("hloadLen", 64'(hrCnt), 64'(ROW + xl));
    expBusy = hrCnt + (m ? 0 : 3 * ROW + COL + 1) + 2 * xl + 1 + nW + stallCyc + 1;
    chk("busyLen", 64'(busyCnt), 64'(expBusy));
    chk("endIdle", 64'(inst), 64'(IDLE_W | (34'(m) << 7)));
  endtask

  initial begin
    int guard, doneSeen;
    reset = 1'b1; start = 1'b0; mode = 1'b0; x_len = '0; x_base = '0; p_base = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rstInst", 64'(inst), 64'(IDLE_W));
    chk("rstReady", 64'(host_ready), 64'd0);
    chk("rstDone", 64'(done), 64'd0);
    chk("rstBusy", 64'(busy), 64'd0);
    reset = 1'b0;

    runPass(1'b0, 4, 11'd0, 11'd100, 0, 1'b0, 1'b0);
    runPass(1'b1, 3, 11'd5, 11'd2044, 0, 1'b1, 1'b0);
    runPass(1'b0, 5, 11'd40, 11'd7, 1, 1'b1, 1'b0);
    runPass(1'b0, 6, 11'd2040, 11'd300, 2, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++)
      runPass(1'($urandom_range(0, 1)), int'($urandom_range(1, 24)), 11'($urandom),
              11'($urandom), 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // zero-length pass
    clearMon(1'b1);
    monOn = 1;
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b1; x_len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("zeroDoneEarly", 64'(done), 64'd0);
    chk("zeroBusy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("zeroDone", 64'(done), 64'd1);
    chk("zeroBusyEnd", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    monOn = 0;
    chk("zeroNoSram", 64'(xWrQ.size() + xRdQ.size() + pWrQ.size() + pRdQ.size()), 64'd0);
    chk("zeroDoneCount", 64'(doneCnt), 64'd1);

    // reset in the middle of EXEC
    hvMode = 0;
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0; x_len = 11'd4; x_base = '0; p_base = '0;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (inst[1] !== 1'b1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("rstExecReached", 64'(inst[1]), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("midRstInst", 64'(inst), 64'(IDLE_W));
    chk("midRstBusy", 64'(busy), 64'd0);
    chk("midRstDone", 64'(done), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    chk("midRstNoDone", 64'(doneSeen), 64'd0);
    chk("midRstIdle", 64'(inst), 64'(IDLE_W));

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Instruction sequencer for the 2D accelerator core.
- Generates the 34-bit per-cycle instruction word that drives the core's xMem, psumMem, L0/IFIFO/OFIFO and PE array.
- Runs a complete tile pass from one start pulse, in either weight-stationary (WS) or output-stationary (OS) mode: host load, kernel load, execute, drain to psumMem.
- Sits between the testbench/host and the core; the host only supplies D_xmem data beats under a valid/ready handshake.

Parameters:
- row, 8, PE array rows = L0 width in vectors.
- col, 8, PE array columns = output vectors per drain.
- addr_bw, 11, SRAM address width (depth 2048).
- len_bw, 11, width of the activation-count field.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  single-cycle pulse; sampled only in IDLE
- mode  in  1  0 = WS, 1 = OS; latched at start
- x_len  in  len_bw  number of activation vectors (1..2047)
- x_base  in  addr_bw  xMem base address, weights then activations
- p_base  in  addr_bw  psumMem base address for results
- host_valid  in  1  host presents a D_xmem beat
- host_ready  out  1  controller accepts the beat this cycle
- ofifo_valid  in  1  core valid output: OFIFO holds a full output vector
- inst  out  34  core instruction word
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on pass completion

Behaviour:
- Instruction fields:
  - [33] acc; [32] pmem CEN; [31] pmem WEN; [30:20] pmem addr; [19] xmem CEN; [18] xmem WEN; [17:7] xmem addr.
  - [6] ofifo_rd; [5] ififo_wr; [4] ififo_rd; [3] l0_rd; [2] l0_wr; [1] execute; [0] load.
  - inst[7] is the mode bit and also xmem addr LSB. xMem addresses are therefore always generated as {x_base[10:1]+k, mode_q}, i.e. they step by 2 with the LSB pinned to mode.
- Idle word:
  - Both CENs = 1, both WENs = 1, all control bits 0, addresses 0, inst[7] = mode_q.
  - inst is registered. inst, host_ready and done are 0 / idle word at reset.
- States: IDLE -> HLOAD -> WREAD -> KLOAD -> XREAD -> EXEC -> DRAIN -> DONE -> IDLE. 3-bit encoding belongs in the package.
- IDLE: on start, latch mode, x_len, x_base, p_base; clear counters.
  - If x_len == 0, go straight to DONE.
  - start outside IDLE is ignored.
- HLOAD:
  - host_ready = 1.
  - Each host_valid & host_ready beat: xCEN = 0, xWEN = 0, addr index k++.
  - After row + x_len beats, go to WREAD.
  - host_ready drops the cycle after the last beat.
- WREAD (WS only; OS skips to XREAD):
  - row cycles of xCEN = 0, xWEN = 1 reads at index 0..row-1.
  - l0_wr asserted one cycle later for each read (1-cycle SRAM latency), so the state lasts row + 1 cycles.
- KLOAD: l0_rd = 1, load = 1 for row cycles, then row + col idle cycles for weight propagation.
- XREAD: x_len reads at index row..row+x_len-1 with l0_wr delayed one cycle; x_len + 1 cycles.
- EXEC:
  - l0_rd = 1, execute = 1 for x_len cycles.
  - In OS, psumMem is read at p_base + j concurrently so psum feeds back.
- DRAIN:
  - Per output: when ofifo_valid = 1, assert ofifo_rd and pmem CEN = 0, WEN = 0 at p_base + j; acc = 1 in OS, 0 in WS.
  - If ofifo_valid = 0, stall: ofifo_rd = 0, pmem CEN = 1.
  - Finish after x_len writes (WS) or col writes (OS).
- DONE: done = 1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^addr_bw; wrap is silent.
- Reset mid-pass: immediate return to IDLE with idle word; no done pulse.

Decomposition:
- Package core_seq_pkg holds:
  - state enum;
  - inst field bit-position localparams;
  - IDLE_INST constant.
- One sub-module: seq_addr_gen, which owns the base+index counter with a 1-cycle delayed strobe for the SRAM read latency.

Test Plan:
- Reset during EXEC (x_len = 4) -> next cycle inst = idle word, busy = 0, no done.
- WS, x_base = 0, x_len = 4, host_valid always 1 -> 12 xMem writes at addresses 0, 2, ..., 22; 8 load cycles; 4 execute cycles; after DRAIN, 4 pmem writes at p_base..p_base+3 with acc = 0; done once.
- OS, mode = 1, x_len = 3 -> every xmem addr is odd (inst[7] = 1); KLOAD skipped; 8 pmem writes with acc = 1.
- host_valid toggling 1,0,1,0 -> writes only on valid cycles; the address index does not advance on gaps.
- ofifo_valid held low for 5 cycles mid-DRAIN -> no ofifo_rd and pmem CEN = 1 for exactly those cycles; the write count still completes.
- start with x_len = 0 -> done two cycles later with no SRAM access; a second start while busy is ignored.
